// File: rtl/battery_sprite_fetch.sv
// -----------------------------------------------------------------------------
// battery_sprite_fetch
//
// Three-stage pixel pipeline that overlays a battery-level sprite on a VGA
// raster. Sprite position, charge level and the low-battery request are
// sampled once per frame (on frame_start), so a moving sprite or level change
// never tears mid-frame.
//
//   edge 1 : box hit test + sprite ROM address
//   edge 2 : ROM read in flight, hit delayed to line up with rom_q
//   edge 3 : transparency key / blink gating -> out_hit, out_index
//
// Optional feature macro: BATTERY_SPRITE_BLINK_EN
//   defined   : low_batt blinks the sprite, toggling every 16 frames
//   undefined : sprite always visible, low_batt ignored
//
// Blink FSM (only with BATTERY_SPRITE_BLINK_EN):
//   state | meaning
//   SHOW  | sprite pixels pass through
//   HIDE  | sprite suppressed (out_hit forced low)
//
// Ports
//   vga_clk      in   pixel clock
//   reset_n      in   async active-low reset
//   frame_start  in   1-cycle pulse at start of vertical blank
//   pix_valid    in   DrawX/DrawY inside the active area
//   DrawX/DrawY  in   current pixel coordinate (10b)
//   BatX/BatY    in   sprite top-left coordinate (10b)
//   level        in   charge level, selects ROM frame (2b)
//   low_batt     in   request blinking
//   rom_addr     out  sprite ROM address (11b, ROM has 1-cycle latency)
//   rom_q        in   ROM data (4b palette index)
//   out_index    out  palette index to downstream lookup
//   out_hit      out  opaque sprite pixel present
// -----------------------------------------------------------------------------
module battery_sprite_fetch #(
    parameter int         SPR_W      = 32,
    parameter int         SPR_H      = 16,
    parameter logic [3:0] TRANSP_IDX = 4'h1
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  BatX,
    input  logic [9:0]  BatY,
    input  logic [1:0]  level,
    input  logic        low_batt,
    output logic [10:0] rom_addr,
    input  logic [3:0]  rom_q,
    output logic [3:0]  out_index,
    output logic        out_hit
);

    localparam int FRAME_PIX = SPR_W * SPR_H;

    // ------------------------------------------------------------------
    // Per-frame shadow registers
    // ------------------------------------------------------------------
    logic [9:0] bat_x_s;
    logic [9:0] bat_y_s;
    logic [1:0] level_s;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            bat_x_s <= '0;
            bat_y_s <= '0;
            level_s <= '0;
        end else if (frame_start) begin
            bat_x_s <= BatX;
            bat_y_s <= BatY;
            level_s <= level;
        end
    end

    // ------------------------------------------------------------------
    // Blink control
    // ------------------------------------------------------------------
    logic visible;

`ifdef BATTERY_SPRITE_BLINK_EN
    typedef enum logic {
        SHOW = 1'b0,
        HIDE = 1'b1
    } blink_t;

    blink_t     blink_state;
    logic [3:0] frame_cnt;

    // The FSM only moves on frame_start and acts on the low_batt value being
    // latched that same cycle, so state + counter are themselves the frame
    // shadow of low_batt; a mid-frame low_batt change cannot affect this frame.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_state <= SHOW;
            frame_cnt   <= '0;
            visible     <= 1'b1;
        end else if (frame_start) begin
            if (!low_batt) begin
                blink_state <= SHOW;
                frame_cnt   <= '0;
                visible     <= 1'b1;
            end else begin
                frame_cnt <= frame_cnt + 4'd1;
                if (frame_cnt == 4'hF) begin
                    case (blink_state)
                        SHOW: begin
                            blink_state <= HIDE;
                            visible     <= 1'b0;
                        end
                        default: begin
                            blink_state <= SHOW;
                            visible     <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end
`else
    logic unused_low_batt;

    assign visible         = 1'b1;
    assign unused_low_batt = low_batt;
`endif

    // ------------------------------------------------------------------
    // Stage 1: hit test and ROM address
    // ------------------------------------------------------------------
    // Compares are done in 11 bits so a box that extends past X=1023 (or
    // Y=1023) does not wrap around to the left/top edge.
    logic [10:0] x_ext, y_ext;
    logic [10:0] x_lo, x_hi, y_lo, y_hi;
    logic [9:0]  dx, dy;
    logic        in_box;
    logic [10:0] addr_next;

    assign x_ext = {1'b0, DrawX};
    assign y_ext = {1'b0, DrawY};
    assign x_lo  = {1'b0, bat_x_s};
    assign y_lo  = {1'b0, bat_y_s};
    assign x_hi  = x_lo + 11'(SPR_W - 1);
    assign y_hi  = y_lo + 11'(SPR_H - 1);

    assign in_box = pix_valid &&
                    (x_ext >= x_lo) && (x_ext <= x_hi) &&
                    (y_ext >= y_lo) && (y_ext <= y_hi);

    assign dx = DrawX - bat_x_s;
    assign dy = DrawY - bat_y_s;

    assign addr_next = 11'(level_s) * 11'(FRAME_PIX)
                     + 11'(dy) * 11'(SPR_W)
                     + 11'(dx);

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic hit1;
    logic hit2;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hit1      <= 1'b0;
            rom_addr  <= '0;
            hit2      <= 1'b0;
            out_hit   <= 1'b0;
            out_index <= '0;
        end else begin
            // edge 1
            hit1     <= in_box;
            rom_addr <= in_box ? addr_next : 11'd0;
            // edge 2: rom_q for this pixel arrives alongside hit2
            hit2     <= hit1;
            // edge 3
            if (hit2 && (rom_q != TRANSP_IDX) && visible) begin
                out_hit   <= 1'b1;
                out_index <= rom_q;
            end else begin
                out_hit   <= 1'b0;
                out_index <= 4'h0;
            end
        end
    end

endmodule

// File: tb/tb_battery_sprite_fetch.sv
module tb_battery_sprite_fetch;

    logic        vga_clk     = 1'b0;
    logic        reset_n     = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_valid   = 1'b0;
    logic [9:0]  DrawX       = '0;
    logic [9:0]  DrawY       = '0;
    logic [9:0]  BatX        = '0;
    logic [9:0]  BatY        = '0;
    logic [1:0]  level       = '0;
    logic        low_batt    = 1'b0;
    logic [10:0] rom_addr;
    logic [3:0]  rom_q       = '0;
    logic [3:0]  out_index;
    logic        out_hit;

`ifdef BATTERY_SPRITE_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    battery_sprite_fetch dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .BatX        (BatX),
        .BatY        (BatY),
        .level       (level),
        .low_batt    (low_batt),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .out_index   (out_index),
        .out_hit     (out_hit)
    );

    always #5 vga_clk = ~vga_clk;

    int cyc = 0;
    always @(posedge vga_clk) cyc++;

    // Sprite ROM contents: 3 + addr[1:0], except address 1025 holds the
    // transparent key 1.
    function automatic logic [3:0] rom_val(input logic [10:0] a);
        if (a == 11'd1025) return 4'h1;
        return 4'h3 + {2'b00, a[1:0]};
    endfunction

    always @(posedge vga_clk) rom_q <= rom_val(rom_addr);

    typedef struct {
        int          due;
        logic [10:0] addr;
    } addr_item_t;

    typedef struct {
        int         due;
        logic       hit;
        logic [3:0] idx;
    } out_item_t;

    addr_item_t addr_q[$];
    out_item_t  out_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares each expectation on the cycle it comes due.
    always @(negedge vga_clk) begin
        while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
            addr_item_t a;
            a = addr_q.pop_front();
            if (a.due < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL addr_stale: got cycle %0d expected cycle %0d", cyc, a.due);
            end else begin
                check("rom_addr", 32'(rom_addr), 32'(a.addr));
            end
        end
        while (out_q.size() > 0 && out_q[0].due <= cyc) begin
            out_item_t o;
            o = out_q.pop_front();
            if (o.due < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL out_stale: got cycle %0d expected cycle %0d", cyc, o.due);
            end else begin
                check("out_hit", 32'(out_hit), 32'(o.hit));
                check("out_index", 32'(out_index), 32'(o.idx));
            end
        end
    end

    // Called at the drive slot (#1 after a rising edge). Inputs are sampled at
    // the next edge: rom_addr is due 1 cycle later, outputs 3 cycles later.
    task automatic drive(input logic fs, input logic pv, input logic [9:0] x, input logic [9:0] y,
                         input logic [10:0] eaddr, input logic ehit, input logic [3:0] eidx);
        frame_start = fs;
        pix_valid   = pv;
        DrawX       = x;
        DrawY       = y;
        addr_q.push_back('{cyc + 1, eaddr});
        out_q.push_back('{cyc + 3, ehit, eidx});
        @(posedge vga_clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic frame(input logic [9:0] bx, input logic [9:0] by, input logic [1:0] lv, input logic lb);
        BatX     = bx;
        BatY     = by;
        level    = lv;
        low_batt = lb;
        drive(1'b1, 1'b0, 10'd0, 10'd0, 11'd0, 1'b0, 4'h0);
    endtask

    initial begin
        int guard;

        // Reset state
        repeat (3) @(posedge vga_clk);
        #1;
        check("reset_rom_addr", 32'(rom_addr), 32'd0);
        check("reset_out_hit", 32'(out_hit), 32'd0);
        check("reset_out_index", 32'(out_index), 32'd0);
        reset_n = 1'b1;

        // Basic hits, boundaries, transparency
        frame(10'd100, 10'd50, 2'd2, 1'b0);
        drive(1, 1, 10'd100, 10'd50, 11'd1024, 1, 4'h3) ;
        drive(0, 1, 10'd101, 10'd50, 11'd1025, 0, 4'h0);
        drive(0, 1, 10'd131, 10'd65, 11'd1535, 1, 4'h6);
        drive(0, 1, 10'd132, 10'd65, 11'd0,    0, 4'h0);
        drive(0, 1, 10'd99,  10'd50, 11'd0,    0, 4'h0);
        drive(0, 1, 10'd100, 10'd49, 11'd0,    0, 4'h0);
        drive(0, 1, 10'd100, 10'd66, 11'd0,    0, 4'h0);
        drive(0, 0, 10'd100, 10'd50, 11'd0,    0, 4'h0);
        drive(0, 1, 10'd102, 10'd51, 11'd1058, 1, 4'h5);

        // Mid-frame BatX change has no effect until frame_start
        BatX = 10'd200;
        drive(0, 1, 10'd100, 10'd50, 11'd1024, 1, 4'h3);
        drive(0, 1, 10'd200, 10'd50, 11'd0,    0, 4'h0);
        // frame_start together with a valid pixel: that pixel uses old shadow
        drive(1, 1, 10'd100, 10'd50, 11'd1024, 1, 4'h3);
        drive(0, 1, 10'd100, 10'd50, 11'd0,    0, 4'h0);
        drive(0, 1, 10'd200, 10'd50, 11'd1024, 1, 4'h3);
        drive(0, 1, 10'd231, 10'd65, 11'd1535, 1, 4'h6);

        // Box past X=1023 must not wrap to the left edge
        frame(10'd1000, 10'd50, 2'd0, 1'b0);
        drive(0, 1, 10'd1023, 10'd50, 11'd23, 1, 4'h6);
        drive(0, 1, 10'd5,    10'd50, 11'd0,  0, 4'h0);
        drive(0, 1, 10'd999,  10'd50, 11'd0,  0, 4'h0);

        // Blink: 16 pulses -> HIDE, 16 more -> SHOW, 16 more -> HIDE, low_batt=0 -> SHOW
        for (int i = 0; i < 16; i++) frame(10'd100, 10'd50, 2'd2, 1'b1);
        drive(0, 1, 10'd100, 10'd50, 11'd1024, !BLINK, BLINK ? 4'h0 : 4'h3);
        drive(0, 1, 10'd131, 10'd65, 11'd1535, !BLINK, BLINK ? 4'h0 : 4'h6);
        for (int i = 0; i < 16; i++) frame(10'd100, 10'd50, 2'd2, 1'b1);
        drive(0, 1, 10'd100, 10'd50, 11'd1024, 1, 4'h3);
        for (int i = 0; i < 16; i++) frame(10'd100, 10'd50, 2'd2, 1'b1);
        drive(0, 1, 10'd100, 10'd50, 11'd1024, !BLINK, BLINK ? 4'h0 : 4'h3);
        frame(10'd100, 10'd50, 2'd2, 1'b0);
        drive(0, 1, 10'd100, 10'd50, 11'd1024, 1, 4'h3);

        // Reset mid-stream
        drive(0, 1, 10'd100, 10'd50, 11'd1024, 1, 4'h3);
        drive(0, 1, 10'd101, 10'd51, 11'd1057, 1, 4'h4);
        #2;
        reset_n = 1'b0;
        addr_q.delete();
        out_q.delete();
        #1;
        check("rst_out_hit", 32'(out_hit), 32'd0);
        check("rst_out_index", 32'(out_index), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        @(posedge vga_clk);
        @(posedge vga_clk);
        #1;
        reset_n = 1'b1;
        addr_q.push_back('{cyc, 11'd0});
        out_q.push_back('{cyc,     1'b0, 4'h0});
        out_q.push_back('{cyc + 1, 1'b0, 4'h0});
        out_q.push_back('{cyc + 2, 1'b0, 4'h0});
        // Shadows cleared: box at (0,0), level 0
        drive(0, 1, 10'd0,  10'd0,  11'd0,   1, 4'h3);
        drive(0, 1, 10'd31, 10'd15, 11'd511, 1, 4'h6);
        drive(0, 1, 10'd32, 10'd0,  11'd0,   0, 4'h0);

        // Drain
        for (int i = 0; i < 4; i++) drive(0, 0, 10'd0, 10'd0, 11'd0, 0, 4'h0);
        guard = 0;
        while ((addr_q.size() > 0 || out_q.size() > 0) && guard < 20) begin
            @(negedge vga_clk);
            guard++;
        end
        #1;
        if (addr_q.size() > 0 || out_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", addr_q.size() + out_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/battery_sprite_fetch.md
BATTERY_SPRITE_FETCH -- requirements
Module: battery_sprite_fetch

Interface
REQ-001 Parameter SPR_W, default 32: sprite width in pixels.
REQ-002 Parameter SPR_H, default 16: sprite height in pixels.
REQ-003 Parameter TRANSP_IDX, default 4'h1: palette index treated as transparent (magenta key).
REQ-004 Port vga_clk  input  1  pixel clock; the only clock.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port frame_start  input  1  one-cycle pulse at the start of vertical blank.
REQ-007 Port pix_valid  input  1  DrawX/DrawY are in the active display area.
REQ-008 Port DrawX, DrawY  input  10 each  current pixel coordinate.
REQ-009 Port BatX, BatY  input  10 each  sprite top-left coordinate.
REQ-010 Port level  input  2  charge level; selects one of 4 ROM frames.
REQ-011 Port low_batt  input  1  requests blinking.
REQ-012 Port rom_addr  output  11  sprite ROM address (synchronous ROM, 1-cycle read latency).
REQ-013 Port rom_q  input  4  ROM read data, valid one cycle after rom_addr.
REQ-014 Port out_index  output  4  palette index for the downstream palette lookup.
REQ-015 Port out_hit  output  1  an opaque sprite pixel is present on out_index.

Function
REQ-016 The block SHALL latch BatX, BatY, level and low_batt into shadow registers only on cycles where frame_start=1; all hit and address math SHALL use the shadow values (no mid-frame tearing).
REQ-017 Stage 1 (edge 1) SHALL register hit1 = pix_valid AND BatX_s<=DrawX<=BatX_s+SPR_W-1 AND BatY_s<=DrawY<=BatY_s+SPR_H-1, using 11-bit unsigned compares so that BatX_s+31>1023 does not wrap.
REQ-018 Stage 1 SHALL register rom_addr = level_s*SPR_W*SPR_H + (DrawY-BatY_s)*SPR_W + (DrawX-BatX_s) when hit1 is true, and rom_addr = 0 otherwise.
REQ-019 Stage 2 (edge 2) SHALL delay hit1 to hit2, aligned with rom_q.
REQ-020 Stage 3 (edge 3) SHALL register out_hit = hit2 AND rom_q!=TRANSP_IDX AND visible, and out_index = rom_q when that expression is true, else 4'h0.
REQ-021 Total latency from DrawX/DrawY/pix_valid to out_index/out_hit SHALL be exactly 3 vga_clk cycles; throughput SHALL be 1 pixel per cycle with no stalls.
REQ-022 Blink FSM states: SHOW and HIDE. A 4-bit frame counter SHALL increment on each frame_start; on wrap from 15 to 0 the state SHALL toggle. visible=1 in SHOW and visible=0 in HIDE.
REQ-023 When low_batt_s=0, the FSM SHALL be forced to SHOW with the counter cleared, taking effect on the same frame_start that latches it.
REQ-024 frame_start coinciding with pix_valid=1 SHALL still latch the shadow registers; that pixel SHALL use the old shadow values.
REQ-025 Out-of-box pixels and pix_valid=0 SHALL produce out_hit=0 and out_index=0 after 3 cycles, independent of rom_q.

Reset
REQ-026 While reset_n=0, the block SHALL asynchronously clear rom_addr, out_index, out_hit, hit1, hit2, all shadow registers and the frame counter to 0, and SHALL set the FSM to SHOW.
REQ-027 Deassertion of reset_n SHALL take effect on the next rising vga_clk edge; the pipeline SHALL refill with out_hit=0 for at least 3 cycles.
REQ-028 Assertion of reset_n=0 mid-line SHALL force out_hit=0 immediately, with no partial pixel emitted.

Configuration
REQ-029 Macro BATTERY_SPRITE_BLINK_EN: when defined, the blink FSM and frame counter SHALL be present as in REQ-022/023; when undefined, they SHALL be omitted, visible SHALL be tied to 1 and low_batt SHALL be ignored.

Verification
REQ-030 Shadow BatX=100, BatY=50, level=2; DrawX=100, DrawY=50, pix_valid=1 -> rom_addr=1024 after 1 cycle; with rom_q=4'h3, out_index=3 and out_hit=1 after 3 cycles.
REQ-031 DrawX=131, DrawY=65 -> rom_addr=1535 (last pixel hit); DrawX=132 -> rom_addr=0 and out_hit=0.
REQ-032 rom_q=4'h1 inside the box -> out_hit=0 and out_index=0.
REQ-033 With BATTERY_SPRITE_BLINK_EN defined and low_batt=1, apply 16 frame_start pulses -> HIDE state, out_hit=0 for in-box opaque pixels; after 16 more pulses -> out_hit=1 again.
REQ-034 BatX changes from 100 to 200 mid-frame without frame_start -> the hit window stays at X=100..131 until the next frame_start.
REQ-035 reset_n pulsed low while streaming in-box pixels -> all outputs 0 immediately; the first valid out_hit appears no earlier than 3 cycles after release.
